// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: CALL/RET sequencer that drives a downstream return-address stack and redirects fetch.
module call_stack_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    input  logic                     is_call,
    input  logic                     is_ret,
    input  logic [AW-1:0]            pc,
    input  logic [AW-1:0]            call_target,
    output logic                     ready,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic [AW-1:0]            stk_data,
    input  logic [AW-1:0]            stk_top,
    output logic                     next_pc_valid,
    output logic [AW-1:0]            next_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               fault_code
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef enum logic [1:0] {IDLE, PUSH, POP, FAULT} state_t;
    state_t state;
    logic [AW-1:0] target;
    logic accept;
    always_comb begin
        ready         = (state == IDLE) && !reset;
        accept        = instr_valid && ready;
        stk_push      = state == PUSH;
        stk_pop       = state == POP;
        next_pc_valid = stk_push || stk_pop;
        // a return address comes straight from the stack in the POP cycle
        next_pc       = stk_pop ? stk_top : target;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            fault_code <= 2'b00;
            stk_data   <= '0;
            target     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (is_call && is_ret) begin
                        state      <= FAULT;
                        fault_code <= 2'b11;
                    end else if (is_call) begin
                        if (count == CW'(DEPTH)) begin
                            state      <= FAULT;
                            fault_code <= 2'b01;
                        end else begin
                            state    <= PUSH;
                            stk_data <= pc + 1'b1;
                            target   <= call_target;
                        end
                    end else if (is_ret) begin
                        if (count == '0) begin
                            state      <= FAULT;
                            fault_code <= 2'b10;
                        end else begin
                            state <= POP;
                        end
                    end
                end
                PUSH: begin
                    count <= count + 1'b1;
                    state <= IDLE;
                end
                POP: begin
                    count <= count - 1'b1;
                    state <= IDLE;
                end
                FAULT: state <= FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: directed CALL/RET scenarios checked every cycle against a return-address-list model.
module tb_call_stack_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    logic clk = 0, reset = 1, instr_valid = 0, is_call = 0, is_ret = 0;
    logic [AW-1:0] pc = '0, call_target = '0, stk_top, stk_data, next_pc;
    logic ready, stk_push, stk_pop, next_pc_valid;
    logic [$clog2(DEPTH):0] count;
    logic [1:0] fault_code;
    int tests = 0, fails = 0;

    call_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .is_call(is_call), .is_ret(is_ret),
        .pc(pc), .call_target(call_target), .ready(ready), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data(stk_data), .stk_top(stk_top), .next_pc_valid(next_pc_valid), .next_pc(next_pc),
        .count(count), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // downstream stack sharing the same reset
    logic [AW-1:0] mem [DEPTH];
    int sp = 0;
    always @(posedge clk) begin
        if (reset) sp <= 0;
        else if (stk_push && sp < DEPTH) begin mem[sp] <= stk_data; sp <= sp + 1; end
        else if (stk_pop && sp > 0) sp <= sp - 1;
    end
    assign stk_top = (sp > 0) ? mem[sp-1] : '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // model: a list of return addresses, an occupancy and a sticky fault code
    logic [AW-1:0] m_ret[$];
    logic [AW-1:0] e_npc, e_data;
    logic [1:0] m_fault = 0;
    int m_cnt = 0, m_delta = 0;
    bit m_busy = 0, e_push = 0, e_pop = 0, e_valid = 0, started = 0;
    always @(posedge clk) begin
        started = 1;
        e_push = 0; e_pop = 0; e_valid = 0;
        if (reset) begin
            m_cnt = 0; m_fault = 0; m_busy = 0; m_ret.delete();
        end else if (m_busy) begin
            m_busy = 0; m_cnt += m_delta;
        end else if (m_fault == 0 && instr_valid) begin
            if (is_call && is_ret) m_fault = 2'b11;
            else if (is_call) begin
                if (m_cnt == DEPTH) m_fault = 2'b01;
                else begin
                    e_push = 1; e_valid = 1; e_data = pc + 16'd1; e_npc = call_target;
                    m_ret.push_back(pc + 16'd1); m_delta = 1; m_busy = 1;
                end
            end else if (is_ret) begin
                if (m_cnt == 0) m_fault = 2'b10;
                else begin
                    e_pop = 1; e_valid = 1; e_npc = m_ret[$];
                    m_ret.pop_back(); m_delta = -1; m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) if (started) begin
        chk("ready", 32'(ready), 32'(!reset && !m_busy && m_fault == 0));
        chk("count", 32'(count), 32'(m_cnt));
        chk("fault_code", 32'(fault_code), 32'(m_fault));
        chk("stk_push", 32'(stk_push), 32'(e_push));
        chk("stk_pop", 32'(stk_pop), 32'(e_pop));
        chk("next_pc_valid", 32'(next_pc_valid), 32'(e_valid));
        if (e_valid) chk("next_pc", 32'(next_pc), 32'(e_npc));
        if (e_push) chk("stk_data", 32'(stk_data), 32'(e_data));
    end

    task automatic do_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    // waits for ready, presents an instruction for cyc edges, returns 1ns into the following cycle
    task automatic issue(input logic c, input logic r, input logic [AW-1:0] p, input logic [AW-1:0] t, input int cyc);
        int n = 0;
        while (!ready && n < 8) begin @(negedge clk); n++; end
        if (!ready) chk("ready_wait", 32'(ready), 32'd1);
        instr_valid = 1; is_call = c; is_ret = r; pc = p; call_target = t;
        repeat (cyc) @(posedge clk);
        #1;
        instr_valid = 0; is_call = 0; is_ret = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_next_pc", 32'(next_pc), 32'd0);
        chk("rst_stk_data", 32'(stk_data), 32'd0);
        // single CALL
        issue(1, 0, 16'h0010, 16'h0200, 1);
        @(negedge clk);
        chk("call_push", 32'(stk_push), 32'd1);
        chk("call_data", 32'(stk_data), 32'h0011);
        chk("call_npc", 32'(next_pc), 32'h0200);
        chk("call_valid", 32'(next_pc_valid), 32'd1);
        @(negedge clk);
        chk("call_count", 32'(count), 32'd1);
        // nested CALL then two RETs
        issue(1, 0, 16'h0200, 16'h0300, 1);
        @(negedge clk); @(negedge clk);
        chk("nest_count2", 32'(count), 32'd2);
        issue(0, 1, 16'h0300, 16'h0000, 1);
        @(negedge clk);
        chk("ret1_npc", 32'(next_pc), 32'h0201);
        chk("ret1_pop", 32'(stk_pop), 32'd1);
        @(negedge clk);
        chk("ret1_count", 32'(count), 32'd1);
        issue(0, 1, 16'h0202, 16'h0000, 1);
        @(negedge clk);
        chk("ret2_npc", 32'(next_pc), 32'h0011);
        @(negedge clk);
        chk("ret2_count", 32'(count), 32'd0);
        // neither CALL nor RET
        issue(0, 0, 16'h0050, 16'h0000, 1);
        @(negedge clk);
        chk("nop_ready", 32'(ready), 32'd1);
        chk("nop_valid", 32'(next_pc_valid), 32'd0);
        // CALL held 3 edges: accepted, ignored, accepted (one per 2 cycles)
        issue(1, 0, 16'h0100, 16'h0400, 3);
        @(negedge clk); @(negedge clk);
        chk("held_count", 32'(count), 32'd2);
        issue(0, 1, 16'h0400, 16'h0000, 1);
        issue(0, 1, 16'h0400, 16'h0000, 1);
        @(negedge clk);
        chk("held_ret_npc", 32'(next_pc), 32'h0101);
        // PC wrap
        issue(1, 0, 16'hFFFF, 16'h0010, 1);
        @(negedge clk);
        chk("wrap_data", 32'(stk_data), 32'h0000);
        // fill to DEPTH then overflow
        for (int i = 0; i < DEPTH - 1; i++) issue(1, 0, 16'h1000 + 16'(i), 16'h2000, 1);
        @(negedge clk); @(negedge clk);
        chk("full_count", 32'(count), 32'(DEPTH));
        issue(1, 0, 16'h3000, 16'h4000, 1);
        @(negedge clk);
        chk("ovf_push", 32'(stk_push), 32'd0);
        chk("ovf_fault", 32'(fault_code), 32'd1);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        instr_valid = 1; is_ret = 1;
        repeat (3) @(negedge clk);
        instr_valid = 0; is_ret = 0;
        chk("ovf_held", 32'(fault_code), 32'd1);
        chk("ovf_ready", 32'(ready), 32'd0);
        // underflow
        do_reset();
        issue(0, 1, 16'h0020, 16'h0000, 1);
        @(negedge clk);
        chk("unf_pop", 32'(stk_pop), 32'd0);
        chk("unf_fault", 32'(fault_code), 32'd2);
        repeat (3) @(negedge clk);
        chk("unf_ready", 32'(ready), 32'd0);
        // illegal
        do_reset();
        issue(1, 1, 16'h0030, 16'h0500, 1);
        @(negedge clk);
        chk("ill_fault", 32'(fault_code), 32'd3);
        chk("ill_push", 32'(stk_push), 32'd0);
        // reset during the PUSH cycle
        do_reset();
        issue(1, 0, 16'h0040, 16'h0600, 1);
        reset = 1;
        @(posedge clk);
        #1;
        chk("mid_push", 32'(stk_push), 32'd0);
        chk("mid_valid", 32'(next_pc_valid), 32'd0);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_data", 32'(stk_data), 32'd0);
        chk("mid_npc", 32'(next_pc), 32'd0);
        reset = 0;
        @(negedge clk);
        chk("mid_ready", 32'(ready), 32'd1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning stack capacity in entries; parameter AW, default 16, meaning address/PC width.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port instr_valid, input, 1, decoded instruction present.
REQ-005 SHALL have port is_call and port is_ret, each input, 1, instruction class.
REQ-006 SHALL have port pc, input, AW, PC of the presented instruction.
REQ-007 SHALL have port call_target, input, AW, CALL destination.
REQ-008 SHALL have port ready, output, 1, instruction accepted when instr_valid && ready.
REQ-009 SHALL have ports stk_push and stk_pop, each output, 1, and stk_data, output, AW: stack write controls.
REQ-010 SHALL have port stk_top, input, AW, current top-of-stack value from the downstream stack (combinational).
REQ-011 SHALL have ports next_pc_valid, output, 1, and next_pc, output, AW: PC redirect to fetch.
REQ-012 SHALL have port count, output, clog2(DEPTH)+1, current occupancy.
REQ-013 SHALL have port fault_code, output, 2: 00 none, 01 overflow, 10 underflow, 11 illegal.

Function
REQ-014 SHALL implement FSM states IDLE, PUSH, POP, FAULT; ready = (state==IDLE) && !reset.
REQ-015 On accept in IDLE with is_call only and count<DEPTH, SHALL go to PUSH at the next edge.
REQ-016 In PUSH, SHALL assert stk_push=1 and stk_data=pc+1 (captured at accept, modulo 2^AW) for exactly one cycle; SHALL assert next_pc_valid=1 with next_pc=captured call_target in the same cycle; count SHALL increment by 1 at the end of that cycle; state SHALL return to IDLE.
REQ-017 On accept with is_ret only and count>0, SHALL go to POP at the next edge.
REQ-018 In POP, SHALL assert stk_pop=1 for one cycle, drive next_pc=stk_top sampled in that cycle, and assert next_pc_valid=1; count SHALL decrement by 1; state SHALL return to IDLE.
REQ-019 Latency: redirect SHALL appear exactly 1 cycle after accept; maximum throughput SHALL be one CALL/RET per 2 cycles.
REQ-020 An accepted instruction with neither is_call nor is_ret SHALL cause no action; ready SHALL stay 1.
REQ-021 CALL accepted with count==DEPTH SHALL cause no push, set fault_code=01, and enter FAULT.
REQ-022 RET accepted with count==0 SHALL cause no pop, set fault_code=10, and enter FAULT.
REQ-023 Accept with is_call && is_ret SHALL cause no stack action, set fault_code=11, and enter FAULT.
REQ-024 FAULT SHALL be terminal until reset: ready=0, no push/pop/redirect, fault_code held.
REQ-025 stk_push and stk_pop SHALL never be asserted in the same cycle; next_pc_valid SHALL be a single-cycle pulse.
REQ-026 instr_valid while ready=0 SHALL be ignored (not accepted, no state change).
REQ-027 count SHALL never exceed DEPTH and never underflow below 0.

Reset
REQ-028 While reset=1 at a clock edge: state=IDLE, count=0, fault_code=00, stk_push=0, stk_pop=0, stk_data=0, next_pc_valid=0, next_pc=0.
REQ-029 Reset SHALL take priority over all other activity, including mid-PUSH/POP (that operation is abandoned, count=0) and FAULT.
REQ-030 The downstream stack SHALL share the same reset so that its pointer and count agree at 0.

Verification
REQ-031 Reset, then CALL pc=0x0010 target=0x0200 -> next cycle stk_push=1, stk_data=0x0011, next_pc=0x0200, valid=1; count=1.
REQ-032 CALL pc=0x0010, CALL pc=0x0200, RET, RET -> redirects 0x0201 then 0x0011; count goes 1,2,1,0.
REQ-033 RET with count=0 -> no stk_pop, fault_code=10, ready=0 held until reset.
REQ-034 DEPTH CALLs, then one more CALL -> no push, fault_code=01, count=DEPTH.
REQ-035 CALL pc=0xFFFF -> stk_data=0x0000 (wrap); is_call&&is_ret -> fault_code=11.
REQ-036 Reset asserted during PUSH cycle -> next cycle all outputs 0, count=0, ready=1 after release.
